// File: rtl/pong_scoreboard_pkg.sv
// Shared Pong definitions: match state encoding and side constants.
// The package is named pong_pkg because future Pong blocks reuse it.
package pong_pkg;

    typedef enum logic {
        PLAY = 1'b0,
        OVER = 1'b1
    } game_state_t;

    localparam logic SIDE_LFT = 1'b1;
    localparam logic SIDE_RGT = 1'b0;

endpackage

// File: rtl/pong_scoreboard_if.sv
// Collision/new-game strobes in, scores and match status out.
// The master modport drives the strobes; the slave modport is the scoreboard.
interface pong_scoreboard_if #(
    parameter int SCORE_W = 4
);
    logic               lft_collision;
    logic               rgt_collision;
    logic               new_game;
    logic [SCORE_W-1:0] lft_score;
    logic [SCORE_W-1:0] rgt_score;
    logic               lft_win;
    logic               rgt_win;
    logic               game_over;
    logic               serve_lft;
    logic               point_pulse;

    modport master (
        output lft_collision, rgt_collision, new_game,
        input  lft_score, rgt_score, lft_win, rgt_win, game_over, serve_lft, point_pulse
    );

    modport slave (
        input  lft_collision, rgt_collision, new_game,
        output lft_score, rgt_score, lft_win, rgt_win, game_over, serve_lft, point_pulse
    );
endinterface

// File: rtl/pong_scoreboard_rise_detect.sv
// 1-bit rising-edge detector: one-cycle pulse when the level goes high.
// The pulse is combinational from the current level so an event counts on its first sampled edge.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pulse
);
    logic prev;
    logic armed;

    // The first edge after reset only loads history, so a level already high at release is not an event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev  <= 1'b0;
            armed <= 1'b0;
        end else begin
            prev  <= level;
            armed <= 1'b1;
        end
    end

    assign pulse = armed & level & ~prev;
endmodule

// File: rtl/pong_scoreboard.sv
// Two-player Pong score keeper: edge-detected wall hits become points,
// with a win-by-margin decision, saturation guard, serve tracking and a point strobe.
module pong_scoreboard
    import pong_pkg::*;
#(
    parameter int SCORE_W   = 4,
    parameter int WIN_SCORE = 5,
    parameter int WIN_BY    = 1
) (
    input  logic              clk,
    input  logic              reset,
    pong_scoreboard_if.slave  bus
);
    localparam int MAX_INT  = (1 << SCORE_W) - 1;
    localparam int WIN_BY_C = (WIN_BY > MAX_INT) ? MAX_INT + 1 : WIN_BY;
    localparam logic [SCORE_W-1:0] MAX    = SCORE_W'(MAX_INT);
    localparam logic [SCORE_W-1:0] WIN_S  = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W:0]   WIN_M  = (SCORE_W + 1)'(WIN_BY_C);

    logic lft_ev, rgt_ev, new_ev;

    rise_detect u_lft (.clk(clk), .reset(reset), .level(bus.lft_collision), .pulse(lft_ev));
    rise_detect u_rgt (.clk(clk), .reset(reset), .level(bus.rgt_collision), .pulse(rgt_ev));
    rise_detect u_new (.clk(clk), .reset(reset), .level(bus.new_game),      .pulse(new_ev));

    game_state_t        state, state_next;
    logic [SCORE_W-1:0] lft_q, lft_next, rgt_q, rgt_next;
    logic               lft_win_q, lft_win_next, rgt_win_q, rgt_win_next;
    logic               serve_q, serve_next, pulse_q, pulse_next;

    // Margin is taken one bit wider and only when the scorer leads, so it can never wrap.
    function automatic logic reaches_win(input logic [SCORE_W-1:0] s, input logic [SCORE_W-1:0] o);
        logic [SCORE_W:0] margin;
        margin = {1'b0, s} - {1'b0, o};
        return (s == MAX) || ((s >= WIN_S) && (s > o) && (margin >= WIN_M));
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= PLAY;
            lft_q     <= '0;
            rgt_q     <= '0;
            lft_win_q <= 1'b0;
            rgt_win_q <= 1'b0;
            serve_q   <= SIDE_LFT;
            pulse_q   <= 1'b0;
        end else begin
            state     <= state_next;
            lft_q     <= lft_next;
            rgt_q     <= rgt_next;
            lft_win_q <= lft_win_next;
            rgt_win_q <= rgt_win_next;
            serve_q   <= serve_next;
            pulse_q   <= pulse_next;
        end
    end

    // new_game outranks collisions; a hit on both walls in one cycle is a void rally.
    always_comb begin
        state_next   = state;
        lft_next     = lft_q;
        rgt_next     = rgt_q;
        lft_win_next = lft_win_q;
        rgt_win_next = rgt_win_q;
        serve_next   = serve_q;
        pulse_next   = 1'b0;
        if (new_ev) begin
            lft_next     = '0;
            rgt_next     = '0;
            lft_win_next = 1'b0;
            rgt_win_next = 1'b0;
            state_next   = PLAY;
            if (lft_win_q)
                serve_next = SIDE_RGT;
            else if (rgt_win_q)
                serve_next = SIDE_LFT;
        end else begin
            case (state)
                PLAY: begin
                    if (rgt_ev && !lft_ev) begin
                        pulse_next = 1'b1;
                        lft_next   = lft_q + 1'b1;
                        serve_next = SIDE_RGT;
                        if (reaches_win(lft_next, rgt_q)) begin
                            lft_win_next = 1'b1;
                            state_next   = OVER;
                        end
                    end else if (lft_ev && !rgt_ev) begin
                        pulse_next = 1'b1;
                        rgt_next   = rgt_q + 1'b1;
                        serve_next = SIDE_LFT;
                        if (reaches_win(rgt_next, lft_q)) begin
                            rgt_win_next = 1'b1;
                            state_next   = OVER;
                        end
                    end
                end
                OVER: begin
                end
                default: state_next = PLAY;
            endcase
        end
    end

    assign bus.lft_score   = lft_q;
    assign bus.rgt_score   = rgt_q;
    assign bus.lft_win     = lft_win_q;
    assign bus.rgt_win     = rgt_win_q;
    assign bus.game_over   = lft_win_q | rgt_win_q;
    assign bus.serve_lft   = serve_q;
    assign bus.point_pulse = pulse_q;
endmodule

// File: tb/tb_pong_scoreboard.sv
// Bench for pong_scoreboard: three parameter sets share one stimulus stream and are
// checked every cycle against a rule-level score model, plus hand-computed literal checks.
module tb_pong_scoreboard;

    localparam int P_MAX [3] = '{15, 15, 3};
    localparam int P_WS  [3] = '{5, 5, 3};
    localparam int P_WB  [3] = '{1, 2, 3};

    logic clk = 1'b0;
    logic reset;
    logic lc, rc, ng;

    int nCompared   = 0;
    int nMismatched = 0;

    pong_scoreboard_if #(.SCORE_W(4)) ifa ();
    pong_scoreboard_if #(.SCORE_W(4)) ifb ();
    pong_scoreboard_if #(.SCORE_W(2)) ifc ();

    assign ifa.lft_collision = lc;
    assign ifa.rgt_collision = rc;
    assign ifa.new_game      = ng;
    assign ifb.lft_collision = lc;
    assign ifb.rgt_collision = rc;
    assign ifb.new_game      = ng;
    assign ifc.lft_collision = lc;
    assign ifc.rgt_collision = rc;
    assign ifc.new_game      = ng;

    pong_scoreboard #(.SCORE_W(4), .WIN_SCORE(5), .WIN_BY(1)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    pong_scoreboard #(.SCORE_W(4), .WIN_SCORE(5), .WIN_BY(2)) dut_b (.clk(clk), .reset(reset), .bus(ifb));
    pong_scoreboard #(.SCORE_W(2), .WIN_SCORE(3), .WIN_BY(3)) dut_c (.clk(clk), .reset(reset), .bus(ifc));

    always #5 clk = ~clk;

    logic [3:0] dLs [3];
    logic [3:0] dRs [3];
    logic [5:0] dFlags [3];

    assign dLs[0] = ifa.lft_score;
    assign dRs[0] = ifa.rgt_score;
    assign dLs[1] = ifb.lft_score;
    assign dRs[1] = ifb.rgt_score;
    assign dLs[2] = {2'b00, ifc.lft_score};
    assign dRs[2] = {2'b00, ifc.rgt_score};
    assign dFlags[0] = {ifa.lft_win, ifa.rgt_win, ifa.game_over, ifa.serve_lft, ifa.point_pulse, 1'b0};
    assign dFlags[1] = {ifb.lft_win, ifb.rgt_win, ifb.game_over, ifb.serve_lft, ifb.point_pulse, 1'b0};
    assign dFlags[2] = {ifc.lft_win, ifc.rgt_win, ifc.game_over, ifc.serve_lft, ifc.point_pulse, 1'b0};

    // Model state: scores as plain integers, a match is over exactly when a win flag is set.
    int ml [3];
    int mr [3];
    bit mlw [3];
    bit mrw [3];
    bit msrv [3];
    bit mpp [3];
    bit pl, pr, pn, justReleased;

    function automatic bit isWin(int d, int s, int o);
        return (s == P_MAX[d]) || (s >= P_WS[d] && s - o >= P_WB[d]);
    endfunction

    task automatic modelStep(int d, bit el, bit er, bit en);
        mpp[d] = 1'b0;
        if (en) begin
            if (mlw[d]) msrv[d] = 1'b0;
            else if (mrw[d]) msrv[d] = 1'b1;
            ml[d] = 0;
            mr[d] = 0;
            mlw[d] = 1'b0;
            mrw[d] = 1'b0;
        end else if (!mlw[d] && !mrw[d] && (el != er)) begin
            mpp[d] = 1'b1;
            if (er) begin
                ml[d] = ml[d] + 1;
                msrv[d] = 1'b0;
                if (isWin(d, ml[d], mr[d])) mlw[d] = 1'b1;
            end else begin
                mr[d] = mr[d] + 1;
                msrv[d] = 1'b1;
                if (isWin(d, mr[d], ml[d])) mrw[d] = 1'b1;
            end
        end
    endtask

    always @(posedge clk or negedge reset) begin
        bit el, er, en;
        if (!reset) begin
            for (int d = 0; d < 3; d++) begin
                ml[d] = 0; mr[d] = 0; mlw[d] = 1'b0; mrw[d] = 1'b0; msrv[d] = 1'b1; mpp[d] = 1'b0;
            end
            pl = 1'b0; pr = 1'b0; pn = 1'b0; justReleased = 1'b1;
        end else begin
            el = lc && !pl && !justReleased;
            er = rc && !pr && !justReleased;
            en = ng && !pn && !justReleased;
            pl = lc; pr = rc; pn = ng; justReleased = 1'b0;
            for (int d = 0; d < 3; d++) modelStep(d, el, er, en);
        end
    end

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        string tag;
        for (int d = 0; d < 3; d++) begin
            tag = (d == 0) ? "A" : (d == 1) ? "B" : "C";
            compare({tag, " lft_score"}, 32'(dLs[d]), 32'(ml[d]));
            compare({tag, " rgt_score"}, 32'(dRs[d]), 32'(mr[d]));
            compare({tag, " lft_win"}, 32'(dFlags[d][5]), 32'(mlw[d]));
            compare({tag, " rgt_win"}, 32'(dFlags[d][4]), 32'(mrw[d]));
            compare({tag, " game_over"}, 32'(dFlags[d][3]), 32'(mlw[d] | mrw[d]));
            compare({tag, " serve_lft"}, 32'(dFlags[d][2]), 32'(msrv[d]));
            compare({tag, " point_pulse"}, 32'(dFlags[d][1]), 32'(mpp[d]));
            compare({tag, " win exclusive"}, 32'(dFlags[d][5] & dFlags[d][4]), 32'd0);
        end
    endtask

    always @(negedge clk) checkOutput();

    // One-edge strobe on the chosen inputs followed by a release; returns where the result is visible.
    task automatic applyStimulus(input bit l, input bit r, input bit n);
        @(negedge clk);
        lc = l; rc = r; ng = n;
        @(negedge clk);
        lc = 1'b0; rc = 1'b0; ng = 1'b0;
    endtask

    task automatic ptLeft();
        applyStimulus(1'b0, 1'b1, 1'b0);
    endtask

    task automatic ptRight();
        applyStimulus(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        lc = 1'b0; rc = 1'b0; ng = 1'b0;
        repeat (2) @(negedge clk);
        compare("reset A lft_score", 32'(ifa.lft_score), 32'd0);
        compare("reset A serve_lft", 32'(ifa.serve_lft), 32'd1);
        compare("reset A game_over", 32'(ifa.game_over), 32'd0);
        reset = 1'b1;

        for (int k = 1; k <= 5; k++) begin
            ptLeft();
            compare("A lft_score per point", 32'(ifa.lft_score), 32'(k));
            compare("A pulse per point", 32'(ifa.point_pulse), 32'd1);
            compare("A lft_win only at 5", 32'(ifa.lft_win), (k == 5) ? 32'd1 : 32'd0);
            if (k == 3) compare("C lft_win at 3-0", 32'(ifc.lft_win), 32'd1);
        end
        compare("A game_over at 5-0", 32'(ifa.game_over), 32'd1);
        compare("A serve after left win", 32'(ifa.serve_lft), 32'd0);
        compare("C frozen at 3", 32'(ifc.lft_score), 32'd3);

        applyStimulus(1'b0, 1'b0, 1'b1);
        compare("A new game lft_score", 32'(ifa.lft_score), 32'd0);
        compare("A new game lft_win", 32'(ifa.lft_win), 32'd0);
        compare("A new game serve to loser", 32'(ifa.serve_lft), 32'd0);

        @(negedge clk);
        rc = 1'b1;
        repeat (20) @(negedge clk);
        rc = 1'b0;
        compare("A held level scores once", 32'(ifa.lft_score), 32'd1);
        compare("A held level no pulse", 32'(ifa.point_pulse), 32'd0);

        applyStimulus(1'b1, 1'b1, 1'b0);
        compare("A void rally lft", 32'(ifa.lft_score), 32'd1);
        compare("A void rally rgt", 32'(ifa.rgt_score), 32'd0);
        compare("A void rally pulse", 32'(ifa.point_pulse), 32'd0);
        compare("A void rally serve", 32'(ifa.serve_lft), 32'd0);

        applyStimulus(1'b0, 1'b1, 1'b1);
        compare("A new_game beats hit score", 32'(ifa.lft_score), 32'd0);
        compare("A new_game beats hit pulse", 32'(ifa.point_pulse), 32'd0);

        for (int k = 0; k < 4; k++) begin
            ptLeft();
            if (k == 2) begin
                compare("C saturation win", 32'(ifc.lft_win), 32'd1);
                compare("C score at MAX", 32'(ifc.lft_score), 32'd3);
                compare("C rgt at 2", 32'(ifc.rgt_score), 32'd2);
            end
            ptRight();
        end
        compare("B at 4-4 rgt", 32'(ifb.rgt_score), 32'd4);
        ptLeft();
        compare("B 5-4 no win", 32'(ifb.lft_win), 32'd0);
        compare("A 5-4 wins", 32'(ifa.lft_win), 32'd1);
        ptRight();
        compare("B 5-5 rgt", 32'(ifb.rgt_score), 32'd5);
        ptLeft();
        compare("B 6-5 no win", 32'(ifb.lft_win), 32'd0);
        ptLeft();
        compare("B 7-5 lft", 32'(ifb.lft_score), 32'd7);
        compare("B 7-5 wins", 32'(ifb.lft_win), 32'd1);

        for (int k = 0; k < 3; k++) ptRight();
        compare("B rgt frozen in OVER", 32'(ifb.rgt_score), 32'd5);
        compare("A rgt frozen in OVER", 32'(ifa.rgt_score), 32'd4);

        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) ptRight();
        compare("A right wins 0-5", 32'(ifa.rgt_win), 32'd1);
        compare("A serve after right win", 32'(ifa.serve_lft), 32'd1);

        applyStimulus(1'b0, 1'b0, 1'b1);
        compare("A serve to loser left", 32'(ifa.serve_lft), 32'd1);
        ptLeft(); ptRight(); ptLeft(); ptRight(); ptLeft();
        compare("A mid-match 3", 32'(ifa.lft_score), 32'd3);

        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        compare("async reset lft", 32'(ifa.lft_score), 32'd0);
        compare("async reset rgt", 32'(ifa.rgt_score), 32'd0);
        compare("async reset serve", 32'(ifa.serve_lft), 32'd1);
        compare("async reset C win", 32'(ifc.lft_win), 32'd0);
        @(negedge clk);
        rc = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        compare("held across release no point", 32'(ifa.lft_score), 32'd0);
        rc = 1'b0;
        ptLeft();
        compare("point after release", 32'(ifa.lft_score), 32'd1);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/pong_scoreboard.md
Name: pong_scoreboard

Overview:
- Parametrised, clocked successor to the two-player Pong score keeper.
- Turns wall-collision strobes from the ball/field logic into per-player scores, a win-by-margin match decision, a serve indicator and a one-cycle point pulse for display and sound blocks.
- Runs on the system clock, with edge detection on all inputs. Replaces the collision-clocked counters.

Parameters:
- SCORE_W, 4, width of each score counter. MAX = 2^SCORE_W-1.
- WIN_SCORE, 5, minimum score needed to win. Must be ≤ MAX; must be ≥ 1.
- WIN_BY, 1, required lead over the opponent at the moment of winning. Must be ≥ 1.

Ports:
- clk, input, 1, system clock. All logic is on its rising edge.
- reset, input, 1, asynchronous, active-low reset.
- lft_collision, input, 1, ball hit the left wall. Level signal synchronous to clk; may stay high for several cycles.
- rgt_collision, input, 1, ball hit the right wall. Same rules as lft_collision.
- new_game, input, 1, synchronous request to start a new match. Level signal; rising edge is detected.
- lft_score, output, SCORE_W, left player score.
- rgt_score, output, SCORE_W, right player score.
- lft_win, output, 1, left player has won the match. Sticky until a new match.
- rgt_win, output, 1, right player has won the match. Sticky until a new match.
- game_over, output, 1, high when lft_win or rgt_win is high.
- serve_lft, output, 1, 1 = left player serves next; 0 = right player serves next.
- point_pulse, output, 1, one-cycle strobe for each point awarded.

Behaviour:
- Reset (reset=0, asynchronous):
  - Scores are 0; lft_win, rgt_win, game_over and point_pulse are 0; serve_lft=1.
  - All edge-detector history registers are cleared to 0. An input that is already high when reset is released does not generate an event.
- Edge detection: an event on an input is input high while its registered copy from the previous cycle is low. One event per rising edge; a held level never scores again.
- Scoring:
  - An rgt_collision event awards a point to the left player.
  - An lft_collision event awards a point to the right player.
- Latency: the point is applied on the first clk edge at which the input is sampled high. The score, point_pulse, serve and win outputs all become visible on that same edge, with no further delay.
- Serve: after each point, the player who conceded the point serves next. For example, a left point sets serve_lft=0.
- State machine, states PLAY and OVER:
  - PLAY: apply points. After a point, call the scorer's new score s and the opponent's score o:
    - If s ≥ WIN_SCORE and s−o ≥ WIN_BY, set the scorer's win flag and go to OVER on that same edge.
    - If s == MAX, the scorer also wins, even when the margin is not met (saturation guard).
    - The score never exceeds MAX.
  - OVER: collision events are ignored. Scores, win flags and serve are frozen; point_pulse stays 0.
  - new_game event, in either state: scores to 0, win flags to 0, go to PLAY. serve_lft is set to the player who lost the match; a restart from PLAY leaves serve_lft unchanged.
- Simultaneous events in the same cycle:
  - new_game has priority over any collision event.
  - Collision events on both sides in the same cycle are a void rally: no point, no pulse, serve unchanged.
- Arithmetic: the margin is computed unsigned at width SCORE_W+1, so it cannot wrap. Each win flag depends only on the scorer's updated value.
- Invariant: lft_win and rgt_win are never both 1.

Decomposition:
- Shared package pong_pkg: state enum {PLAY, OVER} and side constants SIDE_LFT=1, SIDE_RGT=0. Future Pong blocks reuse this package.
- One sub-module, rise_detect: 1-bit rising-edge detector with async active-low reset. Three instances: lft_collision, rgt_collision, new_game.

Test Plan:
- Defaults, reset released, then 5 separate rgt_collision pulses → lft_score 1..5, point_pulse once per pulse, lft_win=1 and game_over=1 on the 5th edge, serve_lft=0.
- rgt_collision held high for 20 cycles → lft_score +1 only, single point_pulse.
- WIN_BY=2, WIN_SCORE=5: bring the score to 4–4, then left scores to 5–4 → no win. Right scores to 5–5, left 6–5, left 7–5 → lft_win on the 7–5 edge only.
- lft_collision and rgt_collision rising in the same cycle → both scores unchanged, no point_pulse, serve unchanged. new_game and a collision in the same cycle → scores 0, state PLAY, no point_pulse.
- In OVER, apply 3 lft_collision pulses → rgt_score frozen. Then a new_game pulse → scores 0/0, flags 0, serve goes to the loser.
- Assert reset in the middle of a 3–2 match → all outputs return to reset values immediately (asynchronously). An input held high across reset release produces no event; SCORE_W=2, WIN_BY=3 → win on reaching MAX=3.
